// File: rtl/seq_pattern_transmitter.sv
// Serial frame transmitter: PATTERN preamble followed by an MSB-first, bit-stuffed payload,
// so that PATTERN appears on the line only where a preamble ends.
module seq_pattern_transmitter #(
  parameter int unsigned      DATA_W     = 8,
  parameter int unsigned      PAT_W      = 4,
  parameter logic [PAT_W-1:0] PATTERN    = 4'b1001,
  parameter int unsigned      GAP_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              out,
  output logic              tx_active,
  output logic              stuff_bit,
  output logic              done,
  output logic [1:0]        currentstate
);

  localparam int unsigned MaxW  = (DATA_W > PAT_W) ? DATA_W : PAT_W;
  localparam int unsigned CntW  = (MaxW > 2) ? $clog2(MaxW) : 1;
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);
  localparam int unsigned HistW = PAT_W - 1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPre  = 2'b01,
    StData = 2'b10,
    StGap  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [PAT_W-1:0]  pre_q, pre_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [HistW-1:0]  hist_q, hist_d;
  logic              out_q, out_d;
  logic              tx_active_q, tx_active_d;
  logic              stuff_q, stuff_d;
  logic              done_q, done_d;
  logic [PAT_W-1:0]  hist_shift;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pre_d       = pre_q;
    data_d      = data_q;
    out_d       = 1'b0;
    tx_active_d = 1'b0;
    stuff_d     = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // First preamble bit leaves on the accept edge itself.
          state_d     = StPre;
          data_d      = data_in;
          out_d       = PATTERN[PAT_W-1];
          pre_d       = PATTERN << 1;
          tx_active_d = 1'b1;
          bit_cnt_d   = CntW'(PAT_W - 2);
        end
      end
      StPre: begin
        out_d       = pre_q[PAT_W-1];
        pre_d       = pre_q << 1;
        tx_active_d = 1'b1;
        if (bit_cnt_q == '0) begin
          state_d   = StData;
          bit_cnt_d = CntW'(DATA_W - 1);
        end else begin
          bit_cnt_d = bit_cnt_q - CntW'(1);
        end
      end
      StData: begin
        tx_active_d = 1'b1;
        // A 0 after the pattern prefix breaks any would-be match; payload pointer holds.
        if (hist_q == PATTERN[PAT_W-1:1]) begin
          stuff_d = 1'b1;
        end else begin
          out_d  = data_q[DATA_W-1];
          data_d = data_q << 1;
          if (bit_cnt_q == '0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q - CntW'(1);
          end
        end
      end
      StGap: begin
        done_d = (gap_cnt_q == '0);
        if (gap_cnt_q == GapW'(GAP_CYCLES)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
    endcase

    hist_shift = {hist_q, out_d};
    hist_d     = hist_shift[HistW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      pre_q       <= '0;
      data_q      <= '0;
      hist_q      <= '0;
      out_q       <= 1'b0;
      tx_active_q <= 1'b0;
      stuff_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pre_q       <= pre_d;
      data_q      <= data_d;
      hist_q      <= hist_d;
      out_q       <= out_d;
      tx_active_q <= tx_active_d;
      stuff_q     <= stuff_d;
      done_q      <= done_d;
    end
  end

  assign ready        = (state_q == StIdle);
  assign out          = out_q;
  assign tx_active    = tx_active_q;
  assign stuff_bit    = stuff_q;
  assign done         = done_q;
  assign currentstate = state_q;

endmodule

// File: doc/seq_pattern_transmitter.md
Name: seq_pattern_transmitter

Overview:
- Serial frame transmitter that drives the line watched by the team's Mealy "1001" sequence detector.
- Each accepted frame is a PATTERN preamble followed by a DATA_W-bit payload, sent MSB first, one bit per clock.
- The payload is bit-stuffed so the pattern never appears outside the preamble. The detector therefore fires exactly once per frame.
- Sits between a parallel producer (start/ready handshake) and the serial line.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- PAT_W, 4, preamble length in bits (>=2).
- PATTERN, 4'b1001, preamble, sent MSB first. PATTERN[0] must be 1.
- GAP_CYCLES, 3, idle-zero cycles after each frame. Must be >= PAT_W-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  frame request; accepted when start && ready at a posedge.
- data_in  input  DATA_W  payload; sampled only on the accept edge.
- ready  output  1  high iff state == IDLE.
- out  output  1  serial line, registered. Idle level is 0.
- tx_active  output  1  registered; high while out carries a preamble, data or stuff bit.
- stuff_bit  output  1  registered; high while out carries an inserted stuff bit.
- done  output  1  registered one-cycle pulse at frame end.
- currentstate  output  2  debug: IDLE=00, PRE=01, DATA=10, GAP=11.

Behaviour:
- Reset (async, reset_n low) forces, immediately and regardless of clk:
  - state=IDLE, out=0, tx_active=0, stuff_bit=0, done=0;
  - bit/gap counters=0, shadow history=0.
  - A frame in progress is abandoned with no done pulse.
- Shadow history: a PAT_W-1 bit shift register of the last bits driven on out. It updates every cycle, including gap and idle zeros.
- IDLE:
  - out=0.
  - On an accept edge: latch data_in, go to PRE, and drive out<=PATTERN[PAT_W-1] with tx_active<=1 on that same edge. Zero-cycle latency from accept to first bit.
- PRE:
  - Drives PATTERN bits MSB to LSB, one per cycle, PAT_W cycles total.
  - After the LSB, go to DATA.
- DATA, before emitting each payload bit:
  - If history equals PATTERN[PAT_W-1:1], emit a stuff bit 0 (stuff_bit=1) and do not advance the payload pointer.
  - Otherwise emit the next payload bit (MSB first) and advance the pointer.
  - The check is repeated before every payload bit. No stuff is inserted after the last payload bit.
  - After payload bit 0 is driven, go to GAP.
  - Frame length = PAT_W + DATA_W + number of stuffs.
- GAP:
  - out=0, tx_active=0, for GAP_CYCLES cycles.
  - done=1 during the first GAP cycle only.
  - Then go to IDLE.
- Throughput:
  - start held high gives back-to-back frames separated by GAP_CYCLES zeros plus one IDLE cycle.
  - start while not ready is ignored; there is no queuing.
  - data_in changes after the accept edge have no effect.
- Destuffing is the receiver's job. This block only guarantees that the pattern occurs on the line solely at preamble ends.

Test Plan:
- Reset mid-frame: assert reset_n=0 during DATA -> out, tx_active, stuff_bit and done go to 0 asynchronously, ready=1 after release, no done pulse. A new start then sends a full frame.
- data_in=8'hFF -> out = 1001 11111111, 12 tx_active cycles, stuff_bit never high, done high on cycle 13 only, then 3 zeros, then ready=1.
- data_in=8'hA5 -> out = 1001 1010 0 0 101 (13 bits), stuff_bit high only on frame bit index 9.
- data_in=8'h99 -> out = 1001 100 0 1100 0 1 (14 bits), stuff_bit high at indices 7 and 12.
- data_in=8'h00 -> out = 1001 00 0 000000 (13 bits), stuff at index 6.
- start held high, random payloads, 50 frames, with the Mealy 1001 detector on out -> exactly one detection per frame, each aligned to the preamble's final bit. start pulses while busy are ignored, and data_in toggled mid-frame does not alter the bits sent.
